// File: rtl/i2s_transmitter.sv
// I2S (Philips) master transmitter with a one-pair shadow buffer.
// Generates sck/ws/sd from clk; inserts silence and flags underrun when starved.
module i2s_transmitter #(
   parameter int DATA_SIZE = 24,
   parameter int SLOT_BITS = 32,
   parameter int CLK_DIV   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 sample_valid_i,
   output logic                 sample_ready_o,
   input  logic [DATA_SIZE-1:0] left_i,
   input  logic [DATA_SIZE-1:0] right_i,
   output logic                 i2s_sck,
   output logic                 i2s_ws,
   output logic                 i2s_sd,
   output logic                 underrun_o
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int BW         = $clog2(FRAME_BITS);
   localparam int CW         = $clog2(CLK_DIV);

   logic [CW-1:0]        div_cnt_reg;
   logic                 sck_reg;
   logic                 ws_reg;
   logic                 sd_reg;
   logic                 underrun_reg;
   logic [BW-1:0]        bit_reg;
   logic [DATA_SIZE-1:0] shift_l_reg;
   logic [DATA_SIZE-1:0] shift_r_reg;
   logic [DATA_SIZE-1:0] shadow_l_reg;
   logic [DATA_SIZE-1:0] shadow_r_reg;
   logic                 shadow_full_reg;

   logic                 div_wrap;
   logic                 fall_event;
   logic                 frame_start;
   logic                 accept;
   logic [BW-1:0]        bit_next;
   logic [BW-1:0]        pos_next;
   logic                 slot_next;
   logic [DATA_SIZE-1:0] shift_l_next;
   logic [DATA_SIZE-1:0] shift_r_next;
   logic [SLOT_BITS-1:0] slot_word;
   logic [SLOT_BITS-1:0] slot_shifted;
   logic                 ws_next;
   logic                 sd_next;

   always_comb begin
      div_wrap    = (div_cnt_reg == CW'(CLK_DIV - 1));
      fall_event  = enable && div_wrap && sck_reg;
      bit_next    = (bit_reg == BW'(FRAME_BITS - 1)) ? '0 : bit_reg + 1'b1;
      frame_start = fall_event && (bit_next == '0);
      accept      = sample_valid_i && !shadow_full_reg;

      // A starved boundary loads silence; the shadow is consulted as registered.
      shift_l_next = shift_l_reg;
      shift_r_next = shift_r_reg;
      if (frame_start) begin
         shift_l_next = shadow_full_reg ? shadow_l_reg : '0;
         shift_r_next = shadow_full_reg ? shadow_r_reg : '0;
      end

      slot_next = (bit_next >= BW'(SLOT_BITS));
      pos_next  = slot_next ? (bit_next - BW'(SLOT_BITS)) : bit_next;
      slot_word = slot_next ? (SLOT_BITS'(shift_r_next) << (SLOT_BITS - DATA_SIZE))
                            : (SLOT_BITS'(shift_l_next) << (SLOT_BITS - DATA_SIZE));
      slot_shifted = slot_word << pos_next;
      sd_next      = slot_shifted[SLOT_BITS-1];
      ws_next      = (bit_next >= BW'(SLOT_BITS - 1)) && (bit_next <= BW'(FRAME_BITS - 2));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt_reg     <= '0;
         sck_reg         <= 1'b0;
         ws_reg          <= 1'b0;
         sd_reg          <= 1'b0;
         underrun_reg    <= 1'b0;
         bit_reg         <= BW'(FRAME_BITS - 1);
         shift_l_reg     <= '0;
         shift_r_reg     <= '0;
         shadow_l_reg    <= '0;
         shadow_r_reg    <= '0;
         shadow_full_reg <= 1'b0;
      end else begin
         // The handshake stays live while disabled.
         if (frame_start && shadow_full_reg)
            shadow_full_reg <= 1'b0;
         if (accept) begin
            shadow_full_reg <= 1'b1;
            shadow_l_reg    <= left_i;
            shadow_r_reg    <= right_i;
         end

         if (!enable) begin
            div_cnt_reg  <= '0;
            sck_reg      <= 1'b0;
            ws_reg       <= 1'b0;
            sd_reg       <= 1'b0;
            underrun_reg <= 1'b0;
            bit_reg      <= BW'(FRAME_BITS - 1);
         end else begin
            div_cnt_reg  <= div_wrap ? '0 : div_cnt_reg + 1'b1;
            if (div_wrap)
               sck_reg <= ~sck_reg;
            underrun_reg <= frame_start && !shadow_full_reg;
            if (fall_event) begin
               bit_reg     <= bit_next;
               ws_reg      <= ws_next;
               sd_reg      <= sd_next;
               shift_l_reg <= shift_l_next;
               shift_r_reg <= shift_r_next;
            end
         end
      end
   end

   assign sample_ready_o = ~shadow_full_reg;
   assign i2s_sck        = sck_reg;
   assign i2s_ws         = ws_reg;
   assign i2s_sd         = sd_reg;
   assign underrun_o     = underrun_reg;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Randomized scoreboard bench for i2s_transmitter (CLK_DIV=2, 32-bit slots, 24-bit data).
module tb_i2s_transmitter;

   localparam int DS        = 24;
   localparam int SB        = 32;
   localparam int CD        = 2;
   localparam int FB        = 2 * SB;
   localparam int FRAME_CYC = 2 * CD * FB;
   localparam int FIRST_B   = 2 * CD - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          sample_valid_i;
   logic          sample_ready_o;
   logic [DS-1:0] left_i;
   logic [DS-1:0] right_i;
   logic          i2s_sck;
   logic          i2s_ws;
   logic          i2s_sd;
   logic          underrun_o;

   i2s_transmitter #(.DATA_SIZE(DS), .SLOT_BITS(SB), .CLK_DIV(CD)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
      .left_i(left_i), .right_i(right_i),
      .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd), .underrun_o(underrun_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DS-1:0] l;
      logic [DS-1:0] r;
      bit            silent;
   } frame_t;

   int     checks = 0;
   int     failures = 0;
   frame_t shadow_q[$];
   frame_t frame_q[$];
   int     n_en = 0;
   bit     run_q = 1'b0;
   bit     exp_underrun = 1'b0;
   int     frames_pushed = 0;
   int     frames_checked = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: boundaries fall every FRAME_CYC enabled clocks, first at FIRST_B.
   initial begin
      frame_t p;
      bit     acc;
      forever begin
         @(posedge clk);
         acc = sample_valid_i && (shadow_q.size() == 0);
         if (!rst_n) begin
            shadow_q.delete();
            n_en = 0;
            run_q = 1'b0;
            exp_underrun = 1'b0;
         end else begin
            exp_underrun = 1'b0;
            if (enable) begin
               if (n_en % FRAME_CYC == FIRST_B) begin
                  if (shadow_q.size() > 0) begin
                     p = shadow_q.pop_front();
                  end else begin
                     p = '{l: '0, r: '0, silent: 1'b1};
                     exp_underrun = 1'b1;
                  end
                  frame_q.push_back(p);
                  frames_pushed++;
               end
               n_en++;
               run_q = 1'b1;
            end else begin
               n_en = 0;
               run_q = 1'b0;
            end
            if (acc)
               shadow_q.push_back('{l: left_i, r: right_i, silent: 1'b0});
         end
      end
   end

   // Monitor: collects bits on rising sck and compares whole frames.
   initial begin
      frame_t      p;
      int          rcount = 0;
      bit          prev_sck = 1'b0;
      int          b;
      logic [63:0] sd_bits = '0;
      logic [63:0] ws_bits = '0;
      logic [63:0] exp_sd;
      logic [63:0] exp_ws;
      forever begin
         @(negedge clk);
         check("ready", {63'd0, sample_ready_o}, {63'd0, shadow_q.size() == 0});
         check("underrun", {63'd0, underrun_o}, {63'd0, exp_underrun});
         if (!run_q) begin
            check("idle_outputs", {61'd0, i2s_sck, i2s_ws, i2s_sd}, 64'd0);
            rcount = 0;
            prev_sck = 1'b0;
            frame_q.delete();
         end else begin
            if (i2s_sck && !prev_sck) begin
               if (rcount == 0) begin
                  check("pre_frame", {62'd0, i2s_ws, i2s_sd}, 64'd0);
               end else begin
                  b = (rcount - 1) % FB;
                  sd_bits[b] = i2s_sd;
                  ws_bits[b] = i2s_ws;
                  if (b == FB - 1) begin
                     if (frame_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL frame_unexpected actual=frame_emitted required=none");
                     end else begin
                        p = frame_q.pop_front();
                        exp_sd = '0;
                        exp_ws = '0;
                        for (int k = 0; k < FB; k++) begin
                           if (k < DS)
                              exp_sd[k] = p.l[DS-1-k];
                           else if (k >= SB && k - SB < DS)
                              exp_sd[k] = p.r[DS-1-(k-SB)];
                           exp_ws[k] = (k >= SB - 1) && (k <= FB - 2);
                        end
                        check("frame_sd", sd_bits, exp_sd);
                        check("frame_ws", ws_bits, exp_ws);
                        frames_checked++;
                        $display("frame %0d left=%06h right=%06h silent=%0d", frames_checked,
                                 p.l, p.r, p.silent);
                     end
                  end
               end
               rcount++;
            end
            prev_sck = i2s_sck;
         end
      end
   end

   task automatic wait_edges(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic wait_idx(input int target);
      int w = 0;
      @(posedge clk);
      while ((n_en % FRAME_CYC != target) && w < 3 * FRAME_CYC) begin
         @(posedge clk);
         w++;
      end
      #1;
      if (n_en % FRAME_CYC != target) begin
         checks++;
         failures++;
         $display("FAIL wait_idx_timeout actual=%0d required=%0d", n_en % FRAME_CYC, target);
      end
   endtask

   task automatic send(input logic [DS-1:0] l, input logic [DS-1:0] r);
      int w = 0;
      left_i = l;
      right_i = r;
      sample_valid_i = 1'b1;
      @(negedge clk);
      while (!sample_ready_o && w < 3 * FRAME_CYC) begin
         @(negedge clk);
         w++;
      end
      if (!sample_ready_o) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=ready_low required=ready_high");
      end
      @(posedge clk);
      #1;
      sample_valid_i = 1'b0;
      left_i = DS'($urandom);
      right_i = DS'($urandom);
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 1'b0;
      sample_valid_i = 1'b0;
      left_i = '0;
      right_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_edges(8);

      // Known pattern, then sck timing right after enable.
      send(24'hA5A5A5, 24'h123456);
      enable = 1'b1;
      @(negedge clk);
      check("sck_before_first_rise", {63'd0, i2s_sck}, 64'd0);
      @(negedge clk);
      check("sck_before_first_rise2", {63'd0, i2s_sck}, 64'd0);
      @(negedge clk);
      check("sck_first_rise", {63'd0, i2s_sck}, 64'd1);
      @(posedge clk);
      #1;

      // Backpressure: B waits in the handshake until A moves out of the shadow.
      send(DS'($urandom), DS'($urandom));
      send(DS'($urandom), DS'($urandom));

      // Starvation for several frames.
      wait_edges(3 * FRAME_CYC);

      // Valid in the boundary cycle with an empty shadow.
      wait_idx(FIRST_B);
      left_i = DS'($urandom);
      right_i = DS'($urandom);
      sample_valid_i = 1'b1;
      @(posedge clk);
      #1 sample_valid_i = 1'b0;
      wait_edges(FRAME_CYC + 40);

      // Random traffic with random gaps.
      for (int i = 0; i < 6; i++) begin
         wait_edges($urandom_range(0, 300));
         send(DS'($urandom), DS'($urandom));
      end
      wait_edges(2 * FRAME_CYC);

      // Disable mid-frame (b=40) with a pair shadowed, then resume.
      send(DS'($urandom), DS'($urandom));
      send(DS'($urandom), DS'($urandom));
      wait_idx(FIRST_B + 4 * 40 + 2);
      enable = 1'b0;
      wait_edges(10);
      enable = 1'b1;
      wait_edges(2 * FRAME_CYC);

      // Reset mid-frame with a pair shadowed: shadow lost, first frame underruns.
      send(DS'($urandom), DS'($urandom));
      send(DS'($urandom), DS'($urandom));
      wait_idx(FIRST_B + 4 * 40 + 2);
      rst_n = 1'b0;
      wait_edges(2);
      rst_n = 1'b1;
      wait_edges(FRAME_CYC + 20);
      send(DS'($urandom), DS'($urandom));
      wait_idx(2);
      wait_idx(2);
      enable = 1'b0;
      wait_edges(6);

      // Two frames were aborted on purpose; all others must have completed.
      check("frames_done", 64'(frames_checked), 64'(frames_pushed - 2));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
